// File: rtl/spi_burst_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// spi_burst_reg_bridge_if
// Peripheral-side bus between the SPI bridge (master) and the register block
// under test (slave).
//   address      : current bus address
//   data_out     : write data, zero above the transaction width
//   data_write_n : write strobe, 2'b11 idle, else width code
//   data_read_n  : read strobe, same encoding
//   data_in      : read data from the peripheral
//   data_ready   : read data valid
// ---------------------------------------------------------------------------
interface spi_burst_reg_bridge_if #(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 32
);
  logic [ADDR_W-1:0] address;
  logic [REG_W-1:0]  data_out;
  logic [1:0]        data_write_n;
  logic [1:0]        data_read_n;
  logic [REG_W-1:0]  data_in;
  logic              data_ready;

  modport master (
    output address, data_out, data_write_n, data_read_n,
    input  data_in, data_ready
  );

  modport slave (
    input  address, data_out, data_write_n, data_read_n,
    output data_in, data_ready
  );
endinterface

// File: rtl/spi_burst_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_burst_reg_bridge
// SPI mode-0 slave that turns frames (header, address, data words) into
// byte/half/word peripheral bus transactions, with burst transfers, optional
// address auto-increment, read prefetch and underrun detection.
//   clk, rst     : system clock, synchronous active-high reset
//   spi_cs_n     : chip select (async, active-low)
//   spi_clk      : SPI clock (async, mode 0)
//   spi_mosi     : serial data in (async)
//   spi_miso     : serial data out (registered)
//   bus          : peripheral bus (master side)
//   busy         : frame in progress
//   err_underrun : sticky, read data arrived after its word started
// ---------------------------------------------------------------------------
module spi_burst_reg_bridge #(
  parameter int ADDR_W      = 6,
  parameter int REG_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs_n,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  spi_burst_reg_bridge_if.master bus,
  output logic                  busy,
  output logic                  err_underrun
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RDATA = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);

  // Keep the bits of a word that belong to the selected transaction width.
  function automatic logic [REG_W-1:0] width_mask(input logic [1:0] w);
    logic [REG_W-1:0] m;
    case (w)
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Bit index (counting from 0) of the last bit of a data word.
  function automatic logic [5:0] width_last(input logic [1:0] w);
    logic [5:0] l;
    case (w)
      2'b00:   l = 6'd7;
      2'b01:   l = 6'd15;
      default: l = 6'd31;
    endcase
    return l;
  endfunction

  // Byte count of one transaction, used as the address increment.
  function automatic logic [ADDR_W-1:0] width_step(input logic [1:0] w);
    logic [ADDR_W-1:0] s;
    case (w)
      2'b00:   s = ADDR_W'(1);
      2'b01:   s = ADDR_W'(2);
      default: s = ADDR_W'(4);
    endcase
    return s;
  endfunction

  // Move the word's MSB to bit 31 so the miso shifter always shifts out of the top.
  function automatic logic [REG_W-1:0] width_align(input logic [1:0] w, input logic [REG_W-1:0] d);
    logic [REG_W-1:0] a;
    case (w)
      2'b00:   a = {d[7:0], 24'h00_0000};
      2'b01:   a = {d[15:0], 16'h0000};
      default: a = d;
    endcase
    return a;
  endfunction

  // Synchroniser chains and registered edge events
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic cs_prev_q, sck_prev_q;
  logic cs_fall_q, cs_rise_q, sck_rise_q, sck_fall_q, mosi_q;

  // FSM state and datapath registers
  state_t            state_q;
  logic [5:0]        cnt_q;
  logic [REG_W-1:0]  sh_q;
  logic              rw_q, incr_q;
  logic [1:0]        width_q;
  logic [REG_W-1:0]  rsh_q;
  logic [REG_W-1:0]  buf_q;
  logic              buf_valid_q, outst_q, rd_pend_q, inc_pend_q;
  logic [ADDR_W-1:0] address_q;
  logic [REG_W-1:0]  data_out_q;
  logic [1:0]        write_n_q, read_n_q;
  logic              miso_q, busy_q, err_q;

  logic [REG_W-1:0]  sh_next_d;
  logic [REG_W-1:0]  aligned_d;

  assign sh_next_d = {sh_q[REG_W-2:0], mosi_q};
  assign aligned_d = width_align(width_q, buf_q);

  // Input synchronisers; edges and the mosi sample are registered together so they stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      sck_rise_q  <= 1'b0;
      sck_fall_q  <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      cs_fall_q   <= cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
      cs_rise_q   <= ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
      sck_rise_q  <= ~sck_prev_q & sck_sync_q[SYNC_STAGES-1];
      sck_fall_q  <= sck_prev_q & ~sck_sync_q[SYNC_STAGES-1];
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  // Frame FSM with registered bus, miso and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      incr_q      <= 1'b0;
      width_q     <= 2'b00;
      rsh_q       <= '0;
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      outst_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      inc_pend_q  <= 1'b0;
      address_q   <= '0;
      data_out_q  <= '0;
      write_n_q   <= 2'b11;
      read_n_q    <= 2'b11;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      write_n_q <= 2'b11;
      read_n_q  <= 2'b11;
      if (cs_rise_q) begin
        // Frame ends: drop partial words, pending reads and the prefetch buffer.
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        miso_q      <= 1'b0;
        cnt_q       <= 6'd0;
        outst_q     <= 1'b0;
        buf_valid_q <= 1'b0;
        rd_pend_q   <= 1'b0;
        inc_pend_q  <= 1'b0;
      end else begin
        // Write bursts advance the address the cycle after the strobe.
        if (inc_pend_q) begin
          address_q  <= address_q + width_step(width_q);
          inc_pend_q <= 1'b0;
        end
        // Prefetch read issues one cycle after the word start that requested it.
        if (rd_pend_q) begin
          read_n_q  <= width_q;
          outst_q   <= 1'b1;
          rd_pend_q <= 1'b0;
        end
        if (outst_q && bus.data_ready) begin
          buf_q       <= bus.data_in & width_mask(width_q);
          buf_valid_q <= 1'b1;
          outst_q     <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            if (cs_fall_q) begin
              state_q <= ST_HDR;
              busy_q  <= 1'b1;
              cnt_q   <= 6'd0;
              err_q   <= 1'b0;
              miso_q  <= 1'b0;
            end
          end
          ST_HDR: begin
            if (sck_rise_q) begin
              sh_q <= sh_next_d;
              if (cnt_q == 6'd7) begin
                cnt_q   <= 6'd0;
                rw_q    <= sh_next_d[7];
                width_q <= sh_next_d[6:5];
                incr_q  <= sh_next_d[4];
                state_q <= (sh_next_d[6:5] == 2'b11) ? ST_ABORT : ST_ADDR;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise_q) begin
              sh_q <= sh_next_d;
              if (cnt_q == ADDR_LAST) begin
                cnt_q     <= 6'd0;
                address_q <= sh_next_d[ADDR_W-1:0];
                if (rw_q) begin
                  state_q <= ST_WDATA;
                end else begin
                  state_q  <= ST_RDATA;
                  read_n_q <= width_q;
                  outst_q  <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          ST_WDATA: begin
            if (sck_rise_q) begin
              sh_q <= sh_next_d;
              if (cnt_q == width_last(width_q)) begin
                cnt_q      <= 6'd0;
                data_out_q <= sh_next_d & width_mask(width_q);
                write_n_q  <= width_q;
                inc_pend_q <= incr_q;
              end else begin
                cnt_q <= cnt_q + 6'd1;
              end
            end
          end
          ST_RDATA: begin
            if (sck_rise_q) begin
              cnt_q <= (cnt_q == width_last(width_q)) ? 6'd0 : cnt_q + 6'd1;
            end else if (sck_fall_q) begin
              if (cnt_q == 6'd0) begin
                // Word start: hand the buffer to the shifter and prefetch the next word.
                if (buf_valid_q) begin
                  miso_q      <= aligned_d[REG_W-1];
                  rsh_q       <= {aligned_d[REG_W-2:0], 1'b0};
                  buf_valid_q <= 1'b0;
                  rd_pend_q   <= 1'b1;
                  if (incr_q) begin
                    address_q <= address_q + width_step(width_q);
                  end
                end else begin
                  // Underrun: send zeros; the still-outstanding read feeds the next word.
                  miso_q <= 1'b0;
                  rsh_q  <= '0;
                  err_q  <= 1'b1;
                end
              end else begin
                miso_q <= rsh_q[REG_W-1];
                rsh_q  <= {rsh_q[REG_W-2:0], 1'b0};
              end
            end
          end
          ST_ABORT: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign spi_miso         = miso_q;
  assign busy             = busy_q;
  assign err_underrun     = err_q;
  assign bus.address      = address_q;
  assign bus.data_out     = data_out_q;
  assign bus.data_write_n = write_n_q;
  assign bus.data_read_n  = read_n_q;

endmodule

// File: tb/tb_spi_burst_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_burst_reg_bridge
// Drives SPI frames bit by bit, acts as the peripheral (random register
// memory answering reads after a programmable delay) and compares bus
// strobes and miso words against values computed from the frame rules.
// ---------------------------------------------------------------------------
module tb_spi_burst_reg_bridge;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst, spi_cs_n, spi_clk, spi_mosi;
  logic spi_miso, busy, err_underrun;

  spi_burst_reg_bridge_if #(.ADDR_W(6), .REG_W(32)) bus ();

  spi_burst_reg_bridge #(.ADDR_W(6), .REG_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .bus(bus),
    .busy(busy), .err_underrun(err_underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
    logic [1:0]  c;
  } strobe_t;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] mem [64];
  int rd_delay = 2;
  strobe_t wq[$];
  strobe_t rq[$];
  int run_w = 0, run_r = 0, max_run_w = 0, max_run_r = 0, both_cnt = 0;
  logic [31:0] tx [8];
  logic [31:0] rx [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int nbits_of(input logic [1:0] w);
    return (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : (w == 2'b10) ? 32 : 8;
  endfunction

  function automatic logic [31:0] mask_of(input logic [1:0] w);
    return (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  // Address of word k of a burst: start + k * bytes, modulo 64; fixed without incr.
  function automatic logic [5:0] exp_addr(input logic [5:0] a, input int k, input logic [1:0] w, input logic inc);
    int bytes;
    bytes = nbits_of(w) / 8;
    return 6'((int'(a) + (inc ? k * bytes : 0)) & 63);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    wait_clk(HALF);
    spi_clk = 1'b1;
    m = spi_miso;
    wait_clk(HALF);
    spi_clk = 1'b0;
  endtask

  // One complete frame: header, address, nwords full words, extra partial bits.
  task automatic spi_frame(input logic [7:0] hdr, input logic [5:0] a, input int nwords, input int extra);
    int nb;
    logic m;
    logic [31:0] wd;
    nb = nbits_of(hdr[6:5]);
    wq.delete();
    rq.delete();
    max_run_w = 0;
    max_run_r = 0;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) spi_bit(hdr[i], m);
    for (int i = 5; i >= 0; i--) spi_bit(a[i], m);
    for (int w = 0; w < nwords; w++) begin
      wd = tx[w];
      rx[w] = 32'h0;
      for (int i = nb - 1; i >= 0; i--) begin
        spi_bit(wd[i], m);
        rx[w][i] = m;
      end
    end
    wd = tx[nwords];
    for (int i = 0; i < extra; i++) spi_bit(wd[31 - i], m);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(4 * HALF);
  endtask

  task automatic check_wr(input string tag, input int k, input logic [5:0] a, input logic [31:0] d, input logic [1:0] c);
    check({tag, ".addr"}, (k < wq.size()) ? 32'(wq[k].a) : 32'hxxxx_xxxx, 32'(a));
    check({tag, ".data"}, (k < wq.size()) ? wq[k].d : 32'hxxxx_xxxx, d);
    check({tag, ".code"}, (k < wq.size()) ? 32'(wq[k].c) : 32'hxxxx_xxxx, 32'(c));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".miso"}, 32'(spi_miso), 32'h0);
    check({tag, ".address"}, 32'(bus.address), 32'h0);
    check({tag, ".data_out"}, bus.data_out, 32'h0);
    check({tag, ".write_n"}, 32'(bus.data_write_n), 32'h3);
    check({tag, ".read_n"}, 32'(bus.data_read_n), 32'h3);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".err"}, 32'(err_underrun), 32'h0);
  endtask

  // Peripheral model and strobe monitor, sampled on the falling clock edge.
  initial begin : periph
    int cnt;
    logic pend;
    logic [5:0] pa;
    strobe_t s;
    bus.data_ready = 1'b0;
    bus.data_in = 32'h0;
    pend = 1'b0;
    cnt = 0;
    pa = 6'h0;
    forever begin
      @(negedge clk);
      bus.data_ready = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt <= 0) begin
          bus.data_ready = 1'b1;
          bus.data_in = mem[pa];
          pend = 1'b0;
        end
      end
      s.a = bus.address;
      s.d = bus.data_out;
      if (bus.data_write_n != 2'b11) begin
        s.c = bus.data_write_n;
        wq.push_back(s);
        run_w++;
        if (run_w > max_run_w) max_run_w = run_w;
      end else begin
        run_w = 0;
      end
      if (bus.data_read_n != 2'b11) begin
        s.c = bus.data_read_n;
        rq.push_back(s);
        run_r++;
        if (run_r > max_run_r) max_run_r = run_r;
        pend = 1'b1;
        cnt = rd_delay;
        pa = bus.address;
      end else begin
        run_r = 0;
      end
      if (bus.data_write_n != 2'b11 && bus.data_read_n != 2'b11) both_cnt++;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [5:0] a;
    logic [1:0] w;
    logic inc;
    int n;
    logic m;
    rst = 1'b1;
    spi_cs_n = 1'b1;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    wait_clk(4);
    check_reset_vals("reset");
    rst = 1'b0;
    wait_clk(4);

    // 32-bit write of 0xDEADBEEF to 0x05
    tx[0] = 32'hDEAD_BEEF;
    spi_frame(8'hC0, 6'h05, 1, 0);
    check("w32.count", 32'(wq.size()), 32'd1);
    check_wr("w32", 0, 6'h05, 32'hDEAD_BEEF, 2'b10);
    check("w32.pulse", 32'(max_run_w), 32'd1);
    check("w32.noread", 32'(rq.size()), 32'd0);
    check("w32.busy_after", 32'(busy), 32'h0);

    // 8-bit read from 0x10, peripheral answers after 1 clk
    mem[6'h10] = 32'h1234_5678;
    rd_delay = 1;
    spi_frame(8'h00, 6'h10, 1, 0);
    check("r8.miso", rx[0], 32'h0000_0078);
    check("r8.raddr", (rq.size() > 0) ? 32'(rq[0].a) : 32'hxxxx_xxxx, 32'h10);
    check("r8.rcode", (rq.size() > 0) ? 32'(rq[0].c) : 32'hxxxx_xxxx, 32'h0);
    check("r8.pulse", 32'(max_run_r), 32'd1);
    check("r8.nowrite", 32'(wq.size()), 32'd0);
    check("r8.err", 32'(err_underrun), 32'h0);

    // 16-bit incrementing write burst from 0x3E, wrapping past 0x3F
    for (int k = 0; k < 4; k++) tx[k] = $urandom;
    spi_frame(8'hB0, 6'h3E, 3, 0);
    check("wb16.count", 32'(wq.size()), 32'd3);
    for (int k = 0; k < 3; k++) check_wr($sformatf("wb16[%0d]", k), k, exp_addr(6'h3E, k, 2'b01, 1'b1), tx[k] & 32'h0000_FFFF, 2'b01);

    // 32-bit incrementing read burst, data 2 clk after each strobe
    rd_delay = 2;
    a = 6'($urandom);
    spi_frame(8'h50, a, 3, 0);
    for (int k = 0; k < 3; k++) check($sformatf("rb32[%0d]", k), rx[k], mem[exp_addr(a, k, 2'b10, 1'b1)]);
    check("rb32.err", 32'(err_underrun), 32'h0);
    check("rb32.pulse", 32'(max_run_r), 32'd1);

    // Late read data: first word underruns, late data serves the second word
    rd_delay = 14;
    a = 6'($urandom);
    spi_frame(8'h50, a, 3, 0);
    check("under.w0", rx[0], 32'h0);
    check("under.w1", rx[1], mem[exp_addr(a, 0, 2'b10, 1'b1)]);
    check("under.w2", rx[2], mem[exp_addr(a, 1, 2'b10, 1'b1)]);
    check("under.err", 32'(err_underrun), 32'h1);
    rd_delay = 2;
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    check("under.err_clear", 32'(err_underrun), 32'h0);
    check("busy_in_frame", 32'(busy), 32'h1);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    check("busy_idle", 32'(busy), 32'h0);

    // cs_n rises after 5 bits of a write word
    tx[0] = $urandom;
    spi_frame(8'hC0, 6'h07, 0, 5);
    check("partial.nowrite", 32'(wq.size()), 32'd0);
    check("partial.busy", 32'(busy), 32'h0);

    // Width code 11 aborts: no strobes, miso stays 0
    tx[0] = $urandom;
    tx[1] = $urandom;
    spi_frame(8'hE0, 6'h09, 2, 0);
    check("abort_w.nowrite", 32'(wq.size()), 32'd0);
    spi_frame(8'h70, 6'h09, 2, 0);
    check("abort_r.noread", 32'(rq.size()), 32'd0);
    check("abort_r.miso0", rx[0], 32'h0);
    check("abort_r.miso1", rx[1], 32'h0);
    check("abort.busy", 32'(busy), 32'h0);

    // Randomised frames against the burst rules
    for (int it = 0; it < 6; it++) begin
      w = 2'($urandom_range(0, 2));
      inc = 1'($urandom_range(0, 1));
      a = 6'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) tx[k] = $urandom;
      if (it % 2 == 0) begin
        spi_frame({1'b1, w, inc, 4'h0}, a, n, 0);
        check($sformatf("rand%0d.wcount", it), 32'(wq.size()), 32'(n));
        for (int k = 0; k < n; k++)
          check_wr($sformatf("rand%0d.w[%0d]", it, k), k, exp_addr(a, k, w, inc), tx[k] & mask_of(w), w);
      end else begin
        rd_delay = $urandom_range(1, 3);
        spi_frame({1'b0, w, inc, 4'h0}, a, n, 0);
        for (int k = 0; k < n; k++)
          check($sformatf("rand%0d.r[%0d]", it, k), rx[k], mem[exp_addr(a, k, w, inc)] & mask_of(w));
        check($sformatf("rand%0d.err", it), 32'(err_underrun), 32'h0);
      end
    end
    check("strobes_exclusive", 32'(both_cnt), 32'd0);

    // Reset in the middle of a write frame
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) spi_bit(((i == 7) || (i == 6)) ? 1'b1 : 1'b0, m);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m);
    rst = 1'b1;
    wait_clk(1);
    check_reset_vals("rst_mid");
    rst = 1'b0;
    spi_cs_n = 1'b1;
    wait_clk(4 * HALF);
    check("rst_mid.busy_after", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/spi_burst_reg_bridge.md
# spi_burst_reg_bridge

Parametrised SPI-slave-to-register bridge, the next generation of the SPI register access path used to test TinyQV peripherals from the outside. It decodes a SPI mode-0 frame (header, address, one or more data words), drives the peripheral bus with byte/half/word transaction strobes, and adds burst transfers with optional address auto-increment, read-data prefetch and underrun detection. It sits between the chip's uio pads and the peripheral under test, replacing the external synchronizer-plus-glue arrangement with integrated input synchronisers and width masking.

## Interface
- ADDR_W, 6: peripheral address width; sent MSB-first after the header.
- REG_W, 32: bus data width; fixed at 32, since the width code selects 8/16/32 bits.
- SYNC_STAGES, 2: flip-flop stages on spi_cs_n, spi_clk and spi_mosi; minimum 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous and active-high.
- spi_cs_n  in  1  chip select, active-low; asynchronous.
- spi_clk  in  1  SPI clock, mode 0; asynchronous.
- spi_mosi  in  1  serial data in; asynchronous.
- spi_miso  out  1  serial data out; registered.
- address  out  ADDR_W  current bus address.
- data_out  out  REG_W  write data to peripheral; bits above the transaction width are 0.
- data_write_n  out  2  write strobe: 11 = idle, else the width code (00 = 8-bit, 01 = 16-bit, 10 = 32-bit).
- data_read_n  out  2  read strobe; same encoding as data_write_n.
- data_in  in  REG_W  read data from peripheral.
- data_ready  in  1  read data valid; the bridge accepts it only while a read is outstanding.
- busy  out  1  frame in progress (cs asserted and not in IDLE).
- err_underrun  out  1  sticky flag: read data arrived too late.

## Operation
- All SPI inputs pass through the synchronisers. Edges are detected on synced spi_clk. Rising edge samples mosi; falling edge shifts miso.
- Frame layout:
  - header byte: [7] rw (1 = write), [6:5] width code, [4] incr, [3:0] ignored;
  - then ADDR_W address bits;
  - then data words of 8/16/32 bits, MSB first, repeated until cs_n rises.
- States: IDLE, HDR, ADDR, WDATA, RDATA, ABORT.
  - IDLE→HDR: on synced cs_n falling; clears bit counter and err_underrun.
  - HDR→ADDR: after the 8th header bit. Width code 11 goes to ABORT instead: no strobes, miso held 0 until cs_n rises.
  - ADDR→WDATA (rw = 1) or RDATA (rw = 0): after the last address bit; address register loaded.
- WDATA: after the last bit of each word, data_out is loaded (zero-extended) and data_write_n = width for exactly 1 clk. If incr = 1, address advances by 1/2/4 (the byte count) in the cycle after the strobe, wrapping modulo 2^ADDR_W.
- RDATA read strobe and shifting:
  - data_read_n = width for exactly 1 clk, in the cycle after the last address bit is sampled. A read is then outstanding.
  - The first data_ready while outstanding loads the masked data_in into a prefetch buffer and clears outstanding.
  - At each word's first falling edge, the buffer moves to the miso shifter. If incr = 1, address advances and the next read strobe issues 1 clk later (prefetch). If incr = 0, the same address is re-read.
- Underrun: at a word's first falling edge with no buffered data, the shifter loads 0, err_underrun is set, and the outstanding read continues. Data that arrives late is then used for the next word.
- Any cs_n rise goes to IDLE from any state:
  - partial write word discarded, no strobe;
  - outstanding read abandoned; a later data_ready is ignored;
  - miso driven to 0.
- Reset values: spi_miso 0, address 0, data_out 0, data_write_n 11, data_read_n 11, busy 0, err_underrun 0, state IDLE.

## Timing
- Input latency: SYNC_STAGES + 1 clk from pin to edge detect.
- SCK high and low phases must each be ≥ 3 clk; cs_n setup and hold ≥ 3 clk around SCK edges.
- Write strobe: SYNC_STAGES + 2 clk after the rising SCK pin edge of a word's last bit.
- Read deadline: data_ready must assert no later than the falling-edge detect that follows the read strobe. For back-to-back burst words, the deadline is the next word's first falling edge.
- Strobes are never asserted together; at most one read is outstanding.
- data_ready in the same clk as a cs_n-rise detect is ignored.

## Test plan
- Write 32-bit to addr 0x05, data 0xDEADBEEF → one data_write_n = 10 pulse, address 0x05, data_out 0xDEADBEEF, then busy 0 after cs_n rises.
- Read 8-bit from 0x10, peripheral returns 0x12345678 after 1 clk → miso shifts 0x78, data_read_n = 00 for exactly one clk.
- Burst write, incr = 1, 16-bit, start 0x3E, three words → strobes at 0x3E, 0x00, 0x02 (wrap).
- Burst read, incr = 1, 32-bit, 3 words, data_ready 2 clk after each strobe → 3 correct words, err_underrun 0.
- Read with data_ready delayed past the deadline → first word 0x00000000, err_underrun 1; it clears at the next cs_n fall.
- cs_n raised after 5 bits of a write word; also width code 11 → no write strobe, state IDLE; rst mid-frame → all outputs at reset values on the next clk.
